// File: rtl/nes_bus_pkg.sv
// Shared decode constants, DMA state encoding and joypad fill bits for the NES bus controller.
package nes_bus_pkg;

   localparam logic [15:0] RAM_BASE  = 16'h0000;
   localparam logic [15:0] RAM_MASK  = 16'hE000;
   localparam logic [15:0] PPU_BASE  = 16'h2000;
   localparam logic [15:0] PPU_MASK  = 16'hE000;
   localparam logic [15:0] PRG_BASE  = 16'h8000;
   localparam logic [15:0] PRG_MASK  = 16'h8000;
   localparam logic [15:0] DMA_ADDR  = 16'h4014;
   localparam logic [15:0] JOY1_ADDR = 16'h4016;
   localparam logic [15:0] JOY2_ADDR = 16'h4017;

   localparam logic [6:0] JOY_FILL       = 7'b0100000;
   localparam logic [7:0] OPEN_BUS_RESET = 8'hFF;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_ALIGN,
      DMA_ALIGN2,
      DMA_READ,
      DMA_WRITE
   } dma_state_t;

   function automatic logic in_region(input logic [15:0] a, input logic [15:0] base,
                                      input logic [15:0] mask);
      return (a & mask) == base;
   endfunction

endpackage

// File: rtl/nes_bus_ctrl_if.sv
// CPU-side bus of the NES bus controller: the CPU is master, the controller responds.
interface nes_bus_ctrl_if;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic        cpu_rd;
   logic [7:0]  cpu_in;
   logic        cpu_locked;

   modport master (output cpu_address, cpu_out, cpu_we, cpu_rd, input cpu_in, cpu_locked);
   modport slave  (input cpu_address, cpu_out, cpu_we, cpu_rd, output cpu_in, cpu_locked);
endinterface

// File: rtl/nes_joypad.sv
// Joypad serial shifter: reloads from the buttons while strobe is high, shifts right on each read.
module nes_joypad (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       strobe,
   input  logic       shift,
   input  logic [7:0] buttons,
   output logic       data
);
   logic [7:0] sh;

   // Ones shift in from the top so reads past the eighth bit return 1.
   always_ff @(posedge clock) begin
      if (!reset_n)    sh <= 8'h00;
      else if (strobe) sh <= buttons;
      else if (shift)  sh <= {1'b1, sh[7:1]};
   end

   assign data = sh[0];
endmodule

// File: rtl/nes_bus_ctrl.sv
// CPU bus responder: address decode for RAM/PPU/PRG/joypads plus OAM DMA that stalls the CPU.
// Build option NES_BUS_OPENBUS_EN keeps an open-bus latch for unmapped reads; otherwise they return 0xFF.
module nes_bus_ctrl
   import nes_bus_pkg::*;
#(
   parameter bit PRG_16K = 1'b0
) (
   input  logic           clock,
   input  logic           reset_n,
   nes_bus_ctrl_if.slave  bus,
   output logic [10:0]    ram_address,
   output logic [7:0]     ram_wdata,
   output logic           ram_we,
   input  logic [7:0]     ram_rdata,
   output logic [14:0]    prg_address,
   input  logic [7:0]     prg_rdata,
   output logic [2:0]     ppu_reg,
   output logic [7:0]     ppu_wdata,
   output logic           ppu_we,
   output logic           ppu_rd,
   input  logic [7:0]     ppu_rdata,
   output logic [7:0]     oam_address,
   output logic [7:0]     oam_wdata,
   output logic           oam_we,
   input  logic [7:0]     joy1,
   input  logic [7:0]     joy2
);
   dma_state_t  state;
   logic [7:0]  dma_page, dma_idx, dma_data;
   logic        parity, align_odd, joy_strobe, locked_q;
   logic        cpu_ok, is_dma_rd, joy1_bit, joy2_bit;
   logic [15:0] addr;
   logic [7:0]  open_val, rd_data;
   logic [6:0]  joy_hi;

   assign cpu_ok    = (state == DMA_IDLE) && locked_q;
   assign is_dma_rd = (state == DMA_READ);
   assign addr      = is_dma_rd ? {dma_page, dma_idx} : bus.cpu_address;

   assign ram_address = addr[10:0];
   assign ram_wdata   = bus.cpu_out;
   assign prg_address = {(PRG_16K ? 1'b0 : addr[14]), addr[13:0]};
   assign ppu_reg     = bus.cpu_address[2:0];
   assign ppu_wdata   = bus.cpu_out;

   assign ram_we = bus.cpu_we && cpu_ok && in_region(bus.cpu_address, RAM_BASE, RAM_MASK);
   assign ppu_we = bus.cpu_we && cpu_ok && in_region(bus.cpu_address, PPU_BASE, PPU_MASK);
   assign ppu_rd = bus.cpu_rd && cpu_ok && in_region(bus.cpu_address, PPU_BASE, PPU_MASK);

`ifdef NES_BUS_OPENBUS_EN
   logic [7:0] open_bus;

   always_ff @(posedge clock) begin
      if (!reset_n)                  open_bus <= OPEN_BUS_RESET;
      else if (cpu_ok && bus.cpu_we) open_bus <= bus.cpu_out;
      else if (cpu_ok && bus.cpu_rd) open_bus <= rd_data;
   end

   assign open_val = open_bus;
   assign joy_hi   = open_bus[7:1];
`else
   assign open_val = OPEN_BUS_RESET;
   assign joy_hi   = JOY_FILL;
`endif

   // DMA reads must not disturb PPU or joypad state, so those regions read as open bus.
   always_comb begin
      rd_data = open_val;
      if (in_region(addr, RAM_BASE, RAM_MASK))      rd_data = ram_rdata;
      else if (in_region(addr, PPU_BASE, PPU_MASK)) rd_data = is_dma_rd ? open_val : ppu_rdata;
      else if (in_region(addr, PRG_BASE, PRG_MASK)) rd_data = prg_rdata;
      else if (addr == JOY1_ADDR && !is_dma_rd)     rd_data = {joy_hi, joy1_bit};
      else if (addr == JOY2_ADDR && !is_dma_rd)     rd_data = {joy_hi, joy2_bit};
   end

   assign bus.cpu_in     = rd_data;
   assign bus.cpu_locked = locked_q;

   nes_joypad u_joy1 (
      .clock   (clock),
      .reset_n (reset_n),
      .strobe  (joy_strobe),
      .shift   (cpu_ok && bus.cpu_rd && bus.cpu_address == JOY1_ADDR),
      .buttons (joy1),
      .data    (joy1_bit)
   );

   nes_joypad u_joy2 (
      .clock   (clock),
      .reset_n (reset_n),
      .strobe  (joy_strobe),
      .shift   (cpu_ok && bus.cpu_rd && bus.cpu_address == JOY2_ADDR),
      .buttons (joy2),
      .data    (joy2_bit)
   );

   assign oam_address = dma_idx;
   assign oam_wdata   = dma_data;
   assign oam_we      = (state == DMA_WRITE);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= DMA_IDLE;
         locked_q   <= 1'b1;
         dma_page   <= 8'h00;
         dma_idx    <= 8'h00;
         dma_data   <= 8'h00;
         align_odd  <= 1'b0;
         parity     <= 1'b0;
         joy_strobe <= 1'b0;
      end else begin
         parity <= ~parity;
         case (state)
            DMA_IDLE: begin
               if (cpu_ok && bus.cpu_we) begin
                  if (bus.cpu_address == JOY1_ADDR) joy_strobe <= bus.cpu_out[0];
                  if (bus.cpu_address == DMA_ADDR) begin
                     dma_page  <= bus.cpu_out;
                     dma_idx   <= 8'h00;
                     align_odd <= parity;
                     locked_q  <= 1'b0;
                     state     <= DMA_ALIGN;
                  end
               end
            end
            DMA_ALIGN:  state <= align_odd ? DMA_ALIGN2 : DMA_READ;
            DMA_ALIGN2: state <= DMA_READ;
            DMA_READ: begin
               dma_data <= rd_data;
               state    <= DMA_WRITE;
            end
            DMA_WRITE: begin
               dma_idx <= dma_idx + 8'd1;
               if (dma_idx == 8'hFF) begin
                  locked_q <= 1'b1;
                  state    <= DMA_IDLE;
               end else begin
                  state <= DMA_READ;
               end
            end
            default: state <= DMA_IDLE;
         endcase
      end
   end
endmodule
